// File: rtl/wrr_arbiter_pkg.sv
// Shared defaults and types for the weighted round-robin packet arbiter.
package wrr_arbiter_pkg;

  localparam int N_DEF        = 4;
  localparam int DATA_W_DEF   = 32;
  localparam int WEIGHT_W_DEF = 4;
  localparam int SRC_W_DEF    = $clog2(N_DEF);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef logic [SRC_W_DEF-1:0] src_t;

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Rotating find-first: first set request in order (base+1) mod N ... base.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_base,
  output logic                 o_found,
  output logic [$clog2(N)-1:0] o_idx
);
  localparam int SW = $clog2(N);

  logic [SW-1:0] w_idx;

  // Scan farthest-first so the nearest hit after the base overwrites earlier ones.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = SW'((int'(i_base) + k) % N);
      if (i_req[w_idx]) begin
        o_found = 1'b1;
        o_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin packet arbiter: N requesters into one registered output,
// whole packets kept contiguous, each port granted up to weight packets per turn.
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N-1:0][DATA_W-1:0]   i_data,
  input  logic [N-1:0]               i_valid,
  input  logic [N-1:0]               i_last,
  output logic [N-1:0]               o_ready,
  input  logic [N-1:0][WEIGHT_W-1:0] i_weight,
  output logic [DATA_W-1:0]          o_x_data,
  output logic                       o_x_last,
  output logic [$clog2(N)-1:0]       o_x_src,
  output logic                       o_x_valid,
  input  logic                       i_x_ready
);
  localparam int SRC_W = $clog2(N);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [SRC_W-1:0]    r_cur;
  logic [WEIGHT_W-1:0] r_cred;
  logic [SRC_W-1:0]    w_rr_idx;
  logic [SRC_W-1:0]    w_sel;
  logic [SRC_W-1:0]    w_acc_idx;
  logic                w_found;
  logic                w_keep;
  logic                w_can_load;
  logic                w_acc;
  logic [N-1:0]        w_ready;

  logic                r_x_valid;
  logic [DATA_W-1:0]   r_x_data;
  logic                r_x_last;
  logic [SRC_W-1:0]    r_x_src;

  rr_pick #(.N(N)) u_pick (
    .i_req   (i_valid),
    .i_base  (r_cur),
    .o_found (w_found),
    .o_idx   (w_rr_idx)
  );

  assign w_can_load = !r_x_valid || i_x_ready;
  assign w_keep     = (r_cred != '0) && i_valid[r_cur];
  assign w_sel      = w_keep ? r_cur : w_rr_idx;
  assign w_acc_idx  = (r_state == ST_BUSY) ? r_cur : w_sel;
  assign w_acc      = |(w_ready & i_valid);

  // IDLE: between packets, arbitrating | BUSY: packet from r_cur in progress
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_acc && !i_last[w_sel]) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_acc && i_last[r_cur])  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready = '0;
    if (!i_rst) begin
      case (r_state)
        ST_IDLE: if (w_found) w_ready[w_sel] = w_can_load;
        ST_BUSY: w_ready[r_cur] = w_can_load;
        default: w_ready = '0;
      endcase
    end
  end

  // Weight is only looked at when a new turn starts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cur  <= SRC_W'(N - 1);
      r_cred <= '0;
    end else if (r_state == ST_IDLE && w_acc) begin
      r_cur <= w_sel;
      if (w_keep)                   r_cred <= r_cred - WEIGHT_W'(1);
      else if (i_weight[w_sel] == '0) r_cred <= '0;
      else                          r_cred <= i_weight[w_sel] - WEIGHT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x_valid <= 1'b0;
      r_x_data  <= '0;
      r_x_last  <= 1'b0;
      r_x_src   <= '0;
    end else if (w_can_load) begin
      r_x_valid <= w_acc;
      if (w_acc) begin
        r_x_data <= i_data[w_acc_idx];
        r_x_last <= i_last[w_acc_idx];
        r_x_src  <= w_acc_idx;
      end
    end
  end

  assign o_ready   = w_ready;
  assign o_x_valid = r_x_valid;
  assign o_x_data  = r_x_data;
  assign o_x_last  = r_x_last;
  assign o_x_src   = r_x_src;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: behavioural turn/credit model with an expected-beat
// queue checked every cycle, directed scenarios with literal sequences, random traffic.
module tb_wrr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;

  logic                   clk = 1'b0;
  logic                   i_rst;
  logic [N-1:0][DW-1:0]   i_data;
  logic [N-1:0]           i_valid;
  logic [N-1:0]           i_last;
  logic [N-1:0]           o_ready;
  logic [N-1:0][WW-1:0]   i_weight;
  logic [DW-1:0]          o_x_data;
  logic                   o_x_last;
  logic [$clog2(N)-1:0]   o_x_src;
  logic                   o_x_valid;
  logic                   i_x_ready;

  wrr_arbiter #(.N(N), .DATA_W(DW), .WEIGHT_W(WW)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .i_last    (i_last),
    .o_ready   (o_ready),
    .i_weight  (i_weight),
    .o_x_data  (o_x_data),
    .o_x_last  (o_x_last),
    .o_x_src   (o_x_src),
    .o_x_valid (o_x_valid),
    .i_x_ready (i_x_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            src;
  } beat_t;

  beat_t         exp_q[$];
  int            src_log[$];
  logic [DW-1:0] data_log[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  // model state: whose turn it is, packets left in the turn, packet lock
  int            m_cur;
  int            m_cred;
  bit            m_busy;
  int            g;
  bit            cl;
  bit            kept;
  logic [N-1:0]  er;
  beat_t         b;
  logic [N-1:0]  acc;
  int            left[N];
  bit            was;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (i_rst) begin
      chk("rst_x_valid", 64'(o_x_valid), 64'(0));
      chk("rst_ready", 64'(o_ready), 64'(0));
      m_busy = 1'b0;
      m_cur  = N - 1;
      m_cred = 0;
      exp_q.delete();
    end else begin
      chk("x_valid", 64'(o_x_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("x_data", 64'(o_x_data), 64'(exp_q[0].data));
        chk("x_last", 64'(o_x_last), 64'(exp_q[0].last));
        chk("x_src", 64'(o_x_src), 64'(exp_q[0].src));
      end
      cl   = (exp_q.size() == 0) || i_x_ready;
      kept = !m_busy && (m_cred > 0) && i_valid[m_cur];
      g    = -1;
      if (m_busy || kept) g = m_cur;
      else
        for (int k = 1; k <= N; k++)
          if (g < 0 && i_valid[(m_cur + k) % N]) g = (m_cur + k) % N;
      er = '0;
      if (g >= 0 && cl) er[g] = 1'b1;
      chk("ready", 64'(o_ready), 64'(er));

      if (o_x_valid && i_x_ready) begin
        src_log.push_back(int'(o_x_src));
        data_log.push_back(o_x_data);
      end
      if (exp_q.size() != 0 && i_x_ready) void'(exp_q.pop_front());
      if (g >= 0 && cl && i_valid[g]) begin
        b.data = i_data[g];
        b.last = i_last[g];
        b.src  = g;
        exp_q.push_back(b);
        if (!m_busy) begin
          if (kept) m_cred = m_cred - 1;
          else      m_cred = ((i_weight[g] == 0) ? 1 : int'(i_weight[g])) - 1;
          m_cur = g;
        end
        m_busy = !i_last[g];
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic enter_reset();
    @(posedge clk);
    #1;
    i_rst   = 1'b1;
    i_valid = '0;
    i_last  = '0;
    run(2);
    src_log.delete();
    data_log.delete();
  endtask

  initial begin
    i_rst     = 1'b1;
    i_data    = '0;
    i_valid   = '1;
    i_last    = '0;
    i_weight  = '0;
    i_x_ready = 1'b1;
    #1;
    chk("init_x_valid", 64'(o_x_valid), 64'(0));
    chk("init_x_data", 64'(o_x_data), 64'(0));
    chk("init_x_src", 64'(o_x_src), 64'(0));
    chk("init_x_last", 64'(o_x_last), 64'(0));
    chk("init_ready_in_rst", 64'(o_ready), 64'(0));

    // all ports valid, single-beat packets, weight 1: plain rotation
    enter_reset();
    for (int p = 0; p < N; p++) begin
      i_weight[p] = 4'd1;
      i_data[p]   = 32'h1000 + p;
    end
    i_valid = '1; i_last = '1; i_x_ready = 1'b1;
    i_rst = 1'b0;
    run(9);
    chk("rot_count", 64'(src_log.size()), 64'(8));
    for (int i = 0; i < 8 && i < src_log.size(); i++)
      chk("rot_src", 64'(src_log[i]), 64'(i % 4));

    // weights {3,1,1,1}
    enter_reset();
    i_weight[0] = 4'd3;
    i_valid = '1; i_last = '1;
    i_rst = 1'b0;
    run(10);
    chk("wgt_count", 64'(src_log.size()), 64'(9));
    begin
      int exp_seq[9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
      for (int i = 0; i < 9 && i < src_log.size(); i++)
        chk("wgt_src", 64'(src_log[i]), 64'(exp_seq[i]));
    end

    // 4-beat packet from port 1 while port 2 stays valid
    enter_reset();
    i_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    i_valid = 4'b0110; i_last = 4'b0100;
    i_data[1] = 32'h100; i_data[2] = 32'h200;
    i_rst = 1'b0;
    begin
      int bt = 0;
      bit a1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (i_valid[1]) chk("lock_ready2", 64'(o_ready[2]), 64'(0));
        a1 = i_valid[1] && o_ready[1];
        @(posedge clk);
        #1;
        if (a1) begin
          bt++;
          if (bt == 4) i_valid[1] = 1'b0;
          else begin
            i_data[1] = 32'h100 + bt;
            i_last[1] = (bt == 3);
          end
        end
      end
    end
    begin
      int exp_seq[5] = '{1, 1, 1, 1, 2};
      chk("lock_count_ge5", 64'(src_log.size() >= 5), 64'(1));
      for (int i = 0; i < 5 && i < src_log.size(); i++)
        chk("lock_src", 64'(src_log[i]), 64'(exp_seq[i]));
    end

    // downstream stall with a held beat
    enter_reset();
    i_valid = 4'b0001; i_last = 4'b0001; i_data[0] = 32'hDEADBEEF;
    i_x_ready = 1'b0;
    i_rst = 1'b0;
    run(1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_valid", 64'(o_x_valid), 64'(1));
      chk("stall_data", 64'(o_x_data), 64'(32'hDEADBEEF));
      chk("stall_ready", 64'(o_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    i_valid = '0; i_x_ready = 1'b1;
    run(3);
    chk("stall_beats", 64'(src_log.size()), 64'(1));
    if (data_log.size() > 0) chk("stall_beat_data", 64'(data_log[0]), 64'(32'hDEADBEEF));

    // only port 3 valid with weight 0
    enter_reset();
    i_weight[3] = 4'd0;
    i_valid = 4'b1000; i_last = 4'b1000; i_data[3] = 32'h33;
    i_rst = 1'b0;
    run(8);
    chk("w0_count", 64'(src_log.size()), 64'(7));
    for (int i = 0; i < src_log.size(); i++)
      chk("w0_src", 64'(src_log[i]), 64'(3));

    // reset in the middle of a port-2 packet
    enter_reset();
    i_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    i_valid = 4'b0100; i_last = 4'b0000; i_data[2] = 32'h2001;
    i_rst = 1'b0;
    run(1);
    i_data[2] = 32'h2002;
    #2;
    chk("mid_pre_valid", 64'(o_x_valid), 64'(1));
    chk("mid_pre_data", 64'(o_x_data), 64'(32'h2001));
    i_rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(o_x_valid), 64'(0));
    chk("mid_rst_data", 64'(o_x_data), 64'(0));
    chk("mid_rst_src", 64'(o_x_src), 64'(0));
    chk("mid_rst_last", 64'(o_x_last), 64'(0));
    chk("mid_rst_ready", 64'(o_ready), 64'(0));
    run(1);
    src_log.delete();
    data_log.delete();
    i_valid = 4'b0101; i_last = 4'b0101;
    i_data[0] = 32'hA0; i_data[2] = 32'hB0;
    i_rst = 1'b0;
    run(4);
    chk("mid_after_count", 64'(src_log.size()), 64'(3));
    if (src_log.size() >= 2) begin
      chk("mid_after_first", 64'(src_log[0]), 64'(0));
      chk("mid_after_second", 64'(src_log[1]), 64'(2));
    end

    // random traffic against the model
    enter_reset();
    for (int p = 0; p < N; p++) begin
      left[p]     = 0;
      i_weight[p] = WW'($urandom_range(0, 3));
    end
    i_rst = 1'b0;
    repeat (4000) begin
      @(negedge clk);
      acc = i_valid & o_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < N; p++) begin
        was = i_valid[p];
        if (acc[p]) left[p]--;
        if (left[p] == 0 && $urandom_range(0, 1) == 1) left[p] = $urandom_range(1, 4);
        i_valid[p] = (left[p] != 0);
        if (acc[p] || !was) begin
          i_data[p] = $urandom;
          i_last[p] = (left[p] == 1);
        end
      end
      i_x_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0)
        for (int p = 0; p < N; p++) i_weight[p] = WW'($urandom_range(0, 3));
    end
    i_valid   = '0;
    i_x_ready = 1'b1;
    run(4);
    chk("drain_empty", 64'(o_x_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, payload width.
REQ-003 SHALL have parameter WEIGHT_W, default 4, per-port weight width.
REQ-004 SHALL have port i_clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_data  input  N x DATA_W  per-requester payload.
REQ-007 SHALL have port i_valid  input  N  per-requester valid.
REQ-008 SHALL have port i_last  input  N  per-requester end-of-packet flag.
REQ-009 SHALL have port o_ready  output  N  per-requester ready.
REQ-010 SHALL have port i_weight  input  N x WEIGHT_W  packets per turn; value 0 is treated as 1.
REQ-011 SHALL have port o_x_data  output  DATA_W  arbitrated payload.
REQ-012 SHALL have port o_x_last  output  1  arbitrated end-of-packet.
REQ-013 SHALL have port o_x_src  output  clog2(N)  index of the source of the current beat.
REQ-014 SHALL have port o_x_valid  output  1  arbitrated valid.
REQ-015 SHALL have port i_x_ready  input  1  downstream ready.

Function
REQ-016 A transfer SHALL occur on any port when valid and ready are both high at a clock edge.
REQ-017 The output SHALL be a single register stage.
- can_load = !o_x_valid || i_x_ready.
- Latency from upstream accept to o_x_valid SHALL be 1 cycle.
REQ-018 The output register SHALL hold data, last and src stable while o_x_valid=1 and i_x_ready=0.
REQ-019 State SHALL be IDLE (between packets) or BUSY (packet in progress).
- Registers: cur_q (last granted port), cred_q (remaining packets in turn, WEIGHT_W bits).
REQ-020 In IDLE, selection SHALL be:
- sel = cur_q if cred_q>0 and i_valid[cur_q];
- otherwise the first valid port in rotating order (cur_q+1) mod N ... cur_q.
REQ-021 In IDLE, o_ready[sel] SHALL equal can_load, and all other ready bits SHALL be 0.
- If no port is valid, all ready bits SHALL be 0.
REQ-022 On IDLE accept of the first beat:
- cur_q<=sel.
- If sel kept its turn, cred_q<=cred_q-1; otherwise cred_q<=max(i_weight[sel],1)-1.
- Next state SHALL be BUSY if i_last=0, or IDLE if i_last=1.
REQ-023 In BUSY, only o_ready[cur_q]=can_load; all other ready bits SHALL be 0, regardless of other valids (packet lock).
REQ-024 In BUSY, accepting a beat with i_last=1 SHALL return the block to IDLE; cred_q SHALL be unchanged.
REQ-025 Weights SHALL be sampled only at packet start; changes mid-turn SHALL NOT alter cred_q.
REQ-026 A single active requester SHALL be re-granted back-to-back indefinitely (the rotation wraps to itself).
REQ-027 With downstream permanently ready, throughput SHALL be one beat per cycle, including across packet and port switches.
REQ-028 o_ready SHALL depend combinationally on i_x_ready, i_valid and state; it SHALL NOT depend on i_data.

Reset
REQ-029 On i_rst, the following SHALL take effect immediately and asynchronously:
- o_x_valid=0, o_x_data=0, o_x_last=0, o_x_src=0;
- state=IDLE, cur_q=N-1, cred_q=0, so port 0 has first priority.
REQ-030 o_ready SHALL be all 0 while i_rst=1.
REQ-031 Reset mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from port 0.

Structure
REQ-032 Package wrr_arbiter_pkg SHALL hold:
- default N, DATA_W, WEIGHT_W;
- the state enum (IDLE, BUSY);
- the source-index type.
REQ-033 Rotating find-first SHALL be a sub-module rr_pick (inputs: request vector, base index; outputs: found, index).

Verification
REQ-034 Reset release, all four ports valid with single-beat packets, weights all 1, ready=1 -> o_x_src sequence 0,1,2,3,0,...; one beat per cycle.
REQ-035 Weights {3,1,1,1}, all ports valid with single-beat packets, ready=1 -> o_x_src sequence 0,0,0,1,2,3,0,0,0.
REQ-036 Port 1 sends a 4-beat packet while port 2 is valid throughout -> all four port-1 beats are contiguous, then port 2; o_ready[2]=0 during the packet.
REQ-037 o_x_valid=1 with i_x_ready=0 for 5 cycles, payload 0xDEADBEEF -> output held stable; all o_ready=0; no beat lost or duplicated.
REQ-038 Only port 3 valid, weight 0 -> port 3 granted every cycle; behaves as weight 1.
REQ-039 i_rst asserted during beat 2 of a port-2 packet -> outputs zero at once; after release, port 0 is served first when ports 0 and 2 are both valid.
